// File: rtl/pwla_logit.sv
// Pipelined piecewise-linear inverse sigmoid (logit) in Q.10: probability code in [0,1]
// folded about 0.5, nine power-of-two-wide segments, three register stages, global stall.
module pwla_logit #(
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 10,
  parameter int SAT_CODE = 8192
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic        [DATA_W-1:0] f_x,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] x,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int ONE  = 1 << FRAC_W;
  localparam int HALF = ONE / 2;
  localparam int UW   = FRAC_W + 1;
  localparam int MW   = 14;
  localparam int PW   = 19;

  function automatic logic [UW-1:0] bp_y(input logic [3:0] i);
    case (i)
      4'd0:    return UW'(512);
      4'd1:    return UW'(640);
      4'd2:    return UW'(768);
      4'd3:    return UW'(896);
      4'd4:    return UW'(960);
      4'd5:    return UW'(992);
      4'd6:    return UW'(1008);
      4'd7:    return UW'(1016);
      4'd8:    return UW'(1020);
      default: return UW'(1024);
    endcase
  endfunction

  function automatic logic [MW-1:0] bp_x(input logic [3:0] i);
    case (i)
      4'd0:    return MW'(0);
      4'd1:    return MW'(523);
      4'd2:    return MW'(1125);
      4'd3:    return MW'(1993);
      4'd4:    return MW'(2773);
      4'd5:    return MW'(3516);
      4'd6:    return MW'(4243);
      4'd7:    return MW'(4960);
      4'd8:    return MW'(5674);
      default: return MW'(8192);
    endcase
  endfunction

  // log2 of each segment's width, so the slope divide becomes a right shift
  function automatic logic [2:0] bp_k(input logic [3:0] i);
    case (i)
      4'd0, 4'd1, 4'd2: return 3'd7;
      4'd3:             return 3'd6;
      4'd4:             return 3'd5;
      4'd5:             return 3'd4;
      4'd6:             return 3'd3;
      default:          return 3'd2;
    endcase
  endfunction

  function automatic logic [3:0] seg_of(input logic [UW-1:0] u);
    if (u >= UW'(1020)) return 4'd8;
    if (u >= UW'(1016)) return 4'd7;
    if (u >= UW'(1008)) return 4'd6;
    if (u >= UW'(992))  return 4'd5;
    if (u >= UW'(960))  return 4'd4;
    if (u >= UW'(896))  return 4'd3;
    if (u >= UW'(768))  return 4'd2;
    if (u >= UW'(640))  return 4'd1;
    return 4'd0;
  endfunction

  // floor-truncating interpolation; u = 1.0 saturates to SAT_CODE
  function automatic logic [MW-1:0] mag_of(input logic sat, input logic [MW-1:0] xb,
                                           input logic [PW-1:0] prod, input logic [2:0] k);
    if (sat) return MW'(SAT_CODE);
    return xb + MW'(prod >> k);
  endfunction

  function automatic logic signed [DATA_W-1:0] apply_sign(input logic neg, input logic [MW-1:0] m);
    logic signed [DATA_W-1:0] s;
    s = $signed(DATA_W'(m));
    return neg ? -s : s;
  endfunction

  logic advance;
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // Stage 0 -> p0: clamp, fold, segment select
  logic [UW-1:0] c_w, u_w;
  logic          neg_p0_d, sat_p0_d;
  logic [3:0]    seg_p0_d;
  logic [6:0]    off_p0_d;

  always_comb begin
    c_w      = (f_x > DATA_W'(ONE)) ? UW'(ONE) : f_x[UW-1:0];
    neg_p0_d = (c_w < UW'(HALF));
    u_w      = neg_p0_d ? (UW'(ONE) - c_w) : c_w;
    sat_p0_d = (u_w == UW'(ONE));
    seg_p0_d = seg_of(u_w);
    off_p0_d = 7'(u_w - bp_y(seg_p0_d));
  end

  logic       vld_p0_q, neg_p0_q, sat_p0_q;
  logic [3:0] seg_p0_q;
  logic [6:0] off_p0_q;

  // p0 -> p1: slope times offset
  logic [MW-1:0] diff_w;
  logic [PW-1:0] prod_p1_d;

  always_comb begin
    diff_w    = bp_x(4'(seg_p0_q + 4'd1)) - bp_x(seg_p0_q);
    prod_p1_d = PW'(diff_w) * PW'(off_p0_q);
  end

  logic          vld_p1_q, neg_p1_q, sat_p1_q;
  logic [2:0]    k_p1_q;
  logic [MW-1:0] xb_p1_q;
  logic [PW-1:0] prod_p1_q;

  // p1 -> p2: shift, add, sign
  logic signed [DATA_W-1:0] x_p2_d;
  assign x_p2_d = apply_sign(neg_p1_q, mag_of(sat_p1_q, xb_p1_q, prod_p1_q, k_p1_q));

  logic                     vld_p2_q;
  logic signed [DATA_W-1:0] x_p2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0_q  <= 1'b0;
      neg_p0_q  <= 1'b0;
      sat_p0_q  <= 1'b0;
      seg_p0_q  <= '0;
      off_p0_q  <= '0;
      vld_p1_q  <= 1'b0;
      neg_p1_q  <= 1'b0;
      sat_p1_q  <= 1'b0;
      k_p1_q    <= '0;
      xb_p1_q   <= '0;
      prod_p1_q <= '0;
      vld_p2_q  <= 1'b0;
      x_p2_q    <= '0;
    end else if (advance) begin
      vld_p0_q  <= in_valid;
      neg_p0_q  <= neg_p0_d;
      sat_p0_q  <= sat_p0_d;
      seg_p0_q  <= seg_p0_d;
      off_p0_q  <= off_p0_d;
      vld_p1_q  <= vld_p0_q;
      neg_p1_q  <= neg_p0_q;
      sat_p1_q  <= sat_p0_q;
      k_p1_q    <= bp_k(seg_p0_q);
      xb_p1_q   <= bp_x(seg_p0_q);
      prod_p1_q <= prod_p1_d;
      vld_p2_q  <= vld_p1_q;
      x_p2_q    <= x_p2_d;
    end
  end

  assign x         = x_p2_q;
  assign out_valid = vld_p2_q;

endmodule

// File: tb/tb_pwla_logit.sv
// Bench for pwla_logit: directed and random streams scored against a table-driven
// interpolation model, plus latency, stall, bubble, reset and sweep-property checks.
module tb_pwla_logit;

  logic               clk = 1'b0;
  logic               reset;
  logic        [15:0] f_x;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] x;
  logic               out_valid;
  logic               out_ready;

  pwla_logit #(.DATA_W(16), .FRAC_W(10), .SAT_CODE(8192)) dut (
    .clk(clk), .reset(reset), .f_x(f_x), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int YB[10] = '{512, 640, 768, 896, 960, 992, 1008, 1016, 1020, 1024};
  int XB[10] = '{0, 523, 1125, 1993, 2773, 3516, 4243, 4960, 5674, 8192};

  typedef struct { int fx; int exp; } ent_t;
  ent_t q[$];

  int       n_cmp = 0;
  int       n_bad = 0;
  int       n_out = 0;
  int       rdy_run = 0;
  logic [2:0] ah = '0;
  logic     last_acc;
  bit       sweep = 0;
  int       got[0:1024];

  function automatic int ref_logit(int fx);
    int c, u, m;
    bit neg;
    c   = (fx > 1024) ? 1024 : fx;
    neg = (c < 512);
    u   = neg ? 1024 - c : c;
    m   = XB[9];
    for (int i = 0; i < 9; i++)
      if (u >= YB[i] && u < YB[i+1])
        m = XB[i] + ((XB[i+1] - XB[i]) * (u - YB[i])) / (YB[i+1] - YB[i]);
    return neg ? -m : m;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one clock cycle: drive, score transfers before the edge, check state after it
  task automatic cyc(input logic v, input int fx, input logic rdy, input int expv);
    logic acc, xf, stall;
    logic signed [15:0] xold;
    ent_t e;
    f_x = 16'(fx); in_valid = v; out_ready = rdy;
    #1;
    acc   = v & in_ready & ~reset;
    xf    = out_valid & out_ready & ~reset;
    stall = out_valid & ~out_ready & ~reset;
    xold  = x;
    if (stall) chk("in_ready_stall", 32'(in_ready), 0);
    if (xf) begin
      n_cmp++;
      assert (q.size() != 0) else begin
        n_bad++;
        $error("FAIL spurious_output: observed x=%0d expected no output", x);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk($sformatf("x(f_x=%0d)", e.fx), x, e.exp);
        if (sweep && e.fx <= 1024) got[e.fx] = int'(x);
      end
      n_out++;
    end
    if (acc) q.push_back('{fx, expv});
    last_acc = acc;
    @(posedge clk);
    #1;
    if (reset) begin
      q.delete();
      ah = '0;
      chk("reset_out_valid", 32'(out_valid), 0);
      chk("reset_x", x, 0);
    end else begin
      ah = {ah[1:0], acc};
      rdy_run = rdy ? rdy_run + 1 : 0;
      if (stall) begin
        chk("stall_x_hold", x, xold);
        chk("stall_valid_hold", 32'(out_valid), 1);
      end
      if (rdy_run >= 3) chk("latency_valid", 32'(out_valid), 32'(ah[2]));
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) cyc(0, 0, 1, 0);
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    int sent, out0, t;
    int bp[6];
    reset = 1'b1; in_valid = 1'b0; f_x = '0; out_ready = 1'b1;
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    reset = 1'b0;
    cyc(0, 0, 1, 0);
    chk("idle_in_ready", 32'(in_ready), 1);
    chk("idle_out_valid", 32'(out_valid), 0);

    // basic stream with explicit first-result latency
    cyc(1, 512, 1, 0);
    chk("lat_edge1", 32'(out_valid), 0);
    cyc(1, 768, 1, 1125);
    chk("lat_edge2", 32'(out_valid), 0);
    cyc(1, 256, 1, -1125);
    chk("lat_edge3_valid", 32'(out_valid), 1);
    chk("lat_edge3_x", x, 0);
    cyc(1, 832, 1, 1559);
    drain();

    // extremes and clamping
    cyc(1, 0, 1, -8192);
    cyc(1, 1, 1, -7562);
    cyc(1, 1023, 1, 7562);
    cyc(1, 1024, 1, 8192);
    cyc(1, 2000, 1, 8192);
    cyc(1, 65535, 1, 8192);
    drain();

    // breakpoints on both sides of the fold
    for (int i = 0; i < 10; i++) begin
      cyc(1, YB[i], 1, XB[i]);
      cyc(1, 1024 - YB[i], 1, -XB[i]);
    end
    drain();

    // full sweep, then antisymmetry and monotonicity over the captured outputs
    sweep = 1;
    for (int c = 0; c <= 1024; c++) cyc(1, c, 1, ref_logit(c));
    drain();
    sweep = 0;
    for (int c = 0; c <= 1024; c++) chk($sformatf("antisym(%0d)", c), got[c], -got[1024 - c]);
    for (int c = 1; c <= 1024; c++) chk($sformatf("monotonic(%0d)", c), 32'(got[c] >= got[c-1]), 1);

    // backpressure: 6 samples, out_ready low for 5 cycles mid-stream
    bp = '{600, 100, 1000, 900, 30, 700};
    out0 = n_out; sent = 0; t = 0;
    while ((sent < 6 || q.size() != 0) && t < 40) begin
      if (sent < 6) cyc(1, bp[sent], !(t >= 3 && t < 8), ref_logit(bp[sent]));
      else          cyc(0, 0, !(t >= 3 && t < 8), 0);
      if (last_acc) sent++;
      t++;
    end
    chk("bp_all_accepted", sent, 6);
    chk("bp_count_out", n_out - out0, 6);
    chk("bp_queue_empty", q.size(), 0);

    // bubbles
    for (int i = 0; i < 12; i++) begin
      int v;
      v = $urandom_range(0, 1024);
      cyc(i % 2 == 0, v, 1, ref_logit(v));
    end
    drain();

    // reset with three samples in flight
    cyc(1, 900, 1, ref_logit(900));
    cyc(1, 100, 1, ref_logit(100));
    cyc(1, 700, 1, ref_logit(700));
    reset = 1'b1;
    cyc(1, 300, 1, 0);
    reset = 1'b0;
    cyc(1, 960, 1, 2773);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    chk("post_reset_valid", 32'(out_valid), 1);
    chk("post_reset_x", x, 2773);
    drain();

    // random traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      int v;
      v = $urandom_range(0, 1100);
      cyc($urandom_range(0, 3) != 0, v, $urandom_range(0, 3) != 0, ref_logit(v));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
